// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FP add/sub/convert datapath controller.
//   state_t     : controller FSM states
//   OP_ADD/SUB  : op_type encodings of the two add-class operations
//   is_add_sub  : true for op_types that may take the special-result exit
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLASS = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  // Converts share the datapath but always run the full latency,
  // so only op[2:1] == 00 qualifies for the one-cycle special exit.
  function automatic logic is_add_sub(input logic [3:0] op);
    return (op[2:1] == 2'b00);
  endfunction

endpackage

// File: rtl/fpadd_ctrl_if.sv
// Requester/consumer handshake bundle of fpadd_ctrl.
//   req_valid/req_ready : per-requester valid/ready, ready is one-hot or zero
//   req_op/req_tag      : packed per-requester op_type (4 bits) and tag
//   rsp_*               : single response channel with one-hot owner id
// master = requesters and response consumer, slave = the controller.
interface fpadd_ctrl_if #(
  parameter int NREQ = 2,
  parameter int TAGW = 4
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [4*NREQ-1:0]    req_op;
  logic [TAGW*NREQ-1:0] req_tag;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [NREQ-1:0]      rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic                 rsp_invalid;

  modport master (
    output req_valid, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_invalid
  );

  modport slave (
    input  req_valid, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_invalid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk, reset_n : clock, synchronous active-low reset (pointer -> 0)
//   req          : request vector
//   adv          : a grant was taken this cycle; move pointer past grantee
//   grant        : one-hot (or zero) grant, combinational from req and pointer
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // ptr is the index with highest priority this cycle.
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] req_hi;
  logic [NREQ-1:0] pick;

  // Prefer requests at or above the pointer; wrap to the lowest index
  // only when none exist there. Lowest set bit is isolated by x & -x.
  always_comb begin
    hi_mask = ~((NREQ'(1) << ptr) - NREQ'(1));
    req_hi  = req & hi_mask;
    pick    = (req_hi != '0) ? req_hi : req;
    grant   = pick & (~pick + NREQ'(1));
  end

  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/fpadd_ctrl.sv
// Sequencer and round-robin arbiter for the shared multi-cycle FP
// add/sub/convert datapath.
//   clk, reset_n   : clock, synchronous active-low reset
//   bus            : requester/response handshake (fpadd_ctrl_if.slave)
//   dp_sel, dp_op  : registered operand mux select and op_type
//   dp_load        : capture operands (same cycle as the accept)
//   dp_adv         : advance datapath pipeline (every EXEC cycle)
//   dp_res_load    : capture result into output register
//   cls_special/cls_invalid : classifier flags, sampled in CLASS only
//   flush          : abort current operation, drop pending response
//   busy           : controller not idle
module fpadd_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 3,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  fpadd_ctrl_if.slave     bus,
  output logic [NREQ-1:0] dp_sel,
  output logic [3:0]      dp_op,
  output logic            dp_load,
  output logic            dp_adv,
  output logic            dp_res_load,
  input  logic            cls_special,
  input  logic            cls_invalid,
  input  logic            flush,
  output logic            busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic            latch_cls;
  logic            adv_c;
  logic            res_c;
  logic [3:0]      sel_op;
  logic [TAGW-1:0] sel_tag;
  logic [TAGW-1:0] tag_q;
  logic            inv_q;

  // Pointer moves only when the grant is actually taken.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req_valid),
    .adv     (accept),
    .grant   (grant)
  );

  always_comb begin
    sel_op  = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = sel_op  | bus.req_op[4*i +: 4];
        sel_tag = sel_tag | bus.req_tag[TAGW*i +: TAGW];
      end
    end
  end

  // Reset and flush both force IDLE and suppress every pulse, so a
  // requester never sees a ready that the state register will not honour.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    latch_cls = 1'b0;
    adv_c     = 1'b0;
    res_c     = 1'b0;
    if (!reset_n || flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            accept    = 1'b1;
            state_nxt = CLASS;
          end
        end
        CLASS: begin
          latch_cls = 1'b1;
          if (cls_special && is_add_sub(dp_op)) begin
            res_c     = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CW'(LAT - 1);
            state_nxt = EXEC;
          end
        end
        EXEC: begin
          adv_c = 1'b1;
          if (cnt == '0) begin
            res_c     = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        RESP: begin
          // Accepting the next request here gives back-to-back issue.
          if (bus.rsp_ready) begin
            if (|bus.req_valid) begin
              accept    = 1'b1;
              state_nxt = CLASS;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dp_sel <= '0;
      dp_op  <= '0;
      tag_q  <= '0;
      inv_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        dp_sel <= grant;
        dp_op  <= sel_op;
        tag_q  <= sel_tag;
      end
      if (latch_cls) begin
        inv_q <= cls_invalid;
      end
    end
  end

  assign bus.req_ready   = accept ? grant : '0;
  assign dp_load         = accept;
  assign dp_adv          = adv_c;
  assign dp_res_load     = res_c;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = dp_sel;
  assign bus.rsp_tag     = tag_q;
  assign bus.rsp_invalid = inv_q;
  assign busy            = (state != IDLE);

endmodule
